ping_pong_sequencer: RTL and testbench

Sequencer that owns one `Parameterized_Ping_Pong_Counter` instance.
- Accepts queued run programs (max, min, bounce count) from a host and configures the counter for each program.
- Resets the counter, enables it, and forwards user flip requests.
- Ends each run after the programmed number of direction reversals.
- Sits between host/control logic and the counter: all counter inputs come from this block; the counter's outputs feed back into it.

---
 rtl/ping_pong_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_ping_pong_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ping_pong_sequencer.sv
// Sequences queued (max, min, bounces) programs onto an external ping-pong counter.
// Optional PPS_FLIP_EN forwards rising edges of flip_req to the counter during a run.
module ping_pong_sequencer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned BOUNCE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WIDTH-1:0]    cfg_max,
  input  logic [WIDTH-1:0]    cfg_min,
  input  logic [BOUNCE_W-1:0] cfg_bounces,
  input  logic                flip_req,
  input  logic                abort,
  input  logic                cnt_direction,
  input  logic [WIDTH-1:0]    cnt_out,
  output logic                cnt_rst_n,
  output logic                cnt_enable,
  output logic                cnt_flip,
  output logic [WIDTH-1:0]    cnt_max,
  output logic [WIDTH-1:0]    cnt_min,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 2 * WIDTH + BOUNCE_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_RUN, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [ENTRY_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [BOUNCE_W-1:0]  bnc_q, bnc_d, tgt_q, tgt_d;
  logic                 dir_q, dir_d;
  logic [WIDTH-1:0]     cnt_max_q, cnt_max_d, cnt_min_q, cnt_min_d;
  logic                 cnt_rst_n_q, cnt_rst_n_d;
  logic                 cnt_enable_q, cnt_enable_d;
  logic                 cnt_flip_q, cnt_flip_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 full, empty, push_req, push_ok, pop, rev;

`ifdef PPS_FLIP_EN
  logic                 flip_prev_q, flip_prev_d;
  logic                 unused_inputs;
  assign unused_inputs = ^cnt_out;
`else
  logic                 unused_inputs;
  assign unused_inputs = ^{cnt_out, flip_req};
`endif

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign cfg_ready = !full && !abort;
  assign push_req  = cfg_valid && cfg_ready;
  assign push_ok   = push_req && (cfg_max > cfg_min);

  // Next state, FIFO bookkeeping and next-state-aligned registered outputs
  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    bnc_d        = bnc_q;
    tgt_d        = tgt_q;
    dir_d        = dir_q;
    cnt_max_d    = cnt_max_q;
    cnt_min_d    = cnt_min_q;
    cnt_rst_n_d  = 1'b1;
    cnt_enable_d = 1'b0;
    cnt_flip_d   = 1'b0;
    done_d       = 1'b0;
    err_d        = push_req && (cfg_max <= cfg_min);
    pop          = 1'b0;
    rev          = 1'b0;

    if (push_ok) begin
      mem_d[wr_ptr_q] = {cfg_max, cfg_min, cfg_bounces};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop                           = 1'b1;
          {cnt_max_d, cnt_min_d, tgt_d} = mem_q[rd_ptr_q];
          rd_ptr_d                      = rd_ptr_q + PTR_W'(1);
          state_d                       = S_LOAD;
        end
      end
      S_LOAD: begin
        bnc_d   = '0;
        state_d = S_ARM;
      end
      S_ARM: begin
        dir_d   = cnt_direction;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A zero target still gets exactly one enabled cycle
        rev   = (cnt_direction != dir_q);
        bnc_d = bnc_q + BOUNCE_W'(rev);
        dir_d = cnt_direction;
        if ((tgt_q == '0) || (bnc_d == tgt_q)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);

    if (abort) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    case (state_d)
      S_LOAD:  cnt_rst_n_d  = 1'b0;
      S_RUN:   cnt_enable_d = 1'b1;
      S_DONE:  done_d       = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);

`ifdef PPS_FLIP_EN
    flip_prev_d = flip_req;
    cnt_flip_d  = flip_req && !flip_prev_q && (state_q == S_RUN) && !abort;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      bnc_q        <= '0;
      tgt_q        <= '0;
      dir_q        <= 1'b0;
      cnt_max_q    <= '0;
      cnt_min_q    <= '0;
      cnt_rst_n_q  <= 1'b0;
      cnt_enable_q <= 1'b0;
      cnt_flip_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef PPS_FLIP_EN
      flip_prev_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      bnc_q        <= bnc_d;
      tgt_q        <= tgt_d;
      dir_q        <= dir_d;
      cnt_max_q    <= cnt_max_d;
      cnt_min_q    <= cnt_min_d;
      cnt_rst_n_q  <= cnt_rst_n_d;
      cnt_enable_q <= cnt_enable_d;
      cnt_flip_q   <= cnt_flip_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef PPS_FLIP_EN
      flip_prev_q  <= flip_prev_d;
`endif
    end
  end

  // Program storage needs no reset: entries are only read when occupancy says valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign cnt_rst_n  = cnt_rst_n_q;
  assign cnt_enable = cnt_enable_q;
  assign cnt_flip   = cnt_flip_q;
  assign cnt_max    = cnt_max_q;
  assign cnt_min    = cnt_min_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ping_pong_sequencer.sv
// Directed bench for ping_pong_sequencer with a behavioural ping-pong counter attached.
module tb_ping_pong_sequencer;

  logic       clk, rst, cfg_valid, cfg_ready, flip_req, abort;
  logic [3:0] cfg_max, cfg_min, cfg_bounces;
  logic       cnt_direction, cnt_rst_n, cnt_enable, cnt_flip;
  logic [3:0] cnt_out, cnt_max, cnt_min;
  logic       busy, done, err;

  int checks   = 0;
  int failures = 0;

  ping_pong_sequencer dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_max(cfg_max), .cfg_min(cfg_min), .cfg_bounces(cfg_bounces),
    .flip_req(flip_req), .abort(abort), .cnt_direction(cnt_direction),
    .cnt_out(cnt_out), .cnt_rst_n(cnt_rst_n), .cnt_enable(cnt_enable),
    .cnt_flip(cnt_flip), .cnt_max(cnt_max), .cnt_min(cnt_min),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ping-pong counter: bounces at max/min, flip reverses immediately
  logic [3:0] ctr_out;
  logic       ctr_dir, ctr_nd;
  always_comb begin
    if (cnt_flip)                ctr_nd = ~ctr_dir;
    else if (ctr_out == cnt_max) ctr_nd = 1'b0;
    else if (ctr_out == cnt_min) ctr_nd = 1'b1;
    else                         ctr_nd = ctr_dir;
  end
  always @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) begin
      ctr_out <= cnt_min;
      ctr_dir <= 1'b1;
    end else if (cnt_enable) begin
      ctr_out <= ctr_nd ? ctr_out + 4'd1 : ctr_out - 4'd1;
      ctr_dir <= ctr_nd;
    end
  end
  assign cnt_out       = ctr_out;
  assign cnt_direction = ctr_dir;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] mx, input logic [3:0] mn, input logic [3:0] b);
    cfg_valid = 1'b1; cfg_max = mx; cfg_min = mn; cfg_bounces = b;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Ticks until done, counting samples with cnt_enable high before it
  task automatic run_until_done(output int en, output bit seen);
    en = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done === 1'b1) begin seen = 1'b1; break; end
      if (cnt_enable === 1'b1) en++;
    end
  endtask

  int  en, flips, stray;
  bit  seen, started;
  logic [3:0] mx;
  logic [3:0] exp_max [5];
  logic [3:0] exp_min [5];
  int         exp_en  [5];

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_max = '0; cfg_min = '0; cfg_bounces = '0;
    flip_req = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("rst_cnt_rst_n", cnt_rst_n, 0);
    chk("rst_outputs", {cnt_enable, cnt_flip, busy, done, err}, 0);
    chk("rst_max_min", {cnt_max, cnt_min}, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b0;
    tick();
    chk("post_rst_cnt_rst_n", cnt_rst_n, 1);

    // Single run: max=4 min=0 bounces=2
    push(4'd4, 4'd0, 4'd2);
    chk("t1_busy_after_push", busy, 0);
    tick();
    chk("t1_load_rst_n", cnt_rst_n, 0);
    chk("t1_load_busy", busy, 1);
    chk("t1_load_max_min", {cnt_max, cnt_min}, {4'd4, 4'd0});
    tick();
    chk("t1_arm", {cnt_rst_n, cnt_enable}, 2'b10);
    tick();
    chk("t1_run_enable", cnt_enable, 1);
    run_until_done(en, seen);
    chk("t1_done_seen", seen, 1);
    chk("t1_enable_cycles", en, 9);
    chk("t1_done_enable_low", cnt_enable, 0);
    tick();
    chk("t1_done_pulse_one", done, 0);
    chk("t1_idle_busy", busy, 0);

    // Rejected programs: max<min and max==min
    push(4'd2, 4'd5, 4'd1);
    chk("t2_err_lt", err, 1);
    chk("t2_busy_lt", busy, 0);
    tick();
    chk("t2_err_clear", err, 0);
    push(4'd3, 4'd3, 4'd1);
    chk("t2_err_eq", err, 1);
    tick(); tick();
    chk("t2_still_idle", {busy, cnt_enable}, 0);

    // Five accepted pushes, sixth blocked by a full FIFO
    exp_max = '{4'd4, 4'd3, 4'd5, 4'd6, 4'd2};
    exp_min = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
    exp_en  = '{0, 4, 1, 8, 4};
    push(4'd4, 4'd0, 4'd2);
    push(4'd3, 4'd1, 4'd1);
    push(4'd5, 4'd2, 4'd0);
    push(4'd6, 4'd0, 4'd1);
    push(4'd2, 4'd1, 4'd2);
    cfg_valid = 1'b1; cfg_max = 4'd9; cfg_min = 4'd1; cfg_bounces = 4'd1;
    #1;
    chk("t3_full_ready", cfg_ready, 0);
    tick();
    cfg_valid = 1'b0;
    chk("t3_full_no_err", err, 0);
    for (int k = 0; k < 5; k++) begin
      run_until_done(en, seen);
      chk($sformatf("t3_done_%0d", k), seen, 1);
      chk($sformatf("t3_max_min_%0d", k), {cnt_max, cnt_min}, {exp_max[k], exp_min[k]});
      if (k > 0) chk($sformatf("t3_en_%0d", k), en, exp_en[k]);
    end
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) stray++;
    end
    chk("t3_sixth_dropped", stray, 0);

    // Flip requests outside RUN have no effect
    flip_req = 1'b1;
    tick();
    chk("t4_idle_flip0", cnt_flip, 0);
    tick();
    chk("t4_idle_flip1", cnt_flip, 0);
    flip_req = 1'b0;
    tick();

    // Flip held high from out=3 on program (7,0,1)
    push(4'd7, 4'd0, 4'd1);
    flips = 0; en = 0; seen = 1'b0; mx = '0; started = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (cnt_flip === 1'b1) flips++;
      if (done === 1'b1) begin seen = 1'b1; break; end
      if (cnt_enable === 1'b1) en++;
      if (ctr_out > mx) mx = ctr_out;
      if (cnt_enable === 1'b1 && ctr_out == 4'd3 && !started) begin
        flip_req = 1'b1; started = 1'b1;
      end
    end
    flip_req = 1'b0;
    chk("t4_done_seen", seen, 1);
`ifdef PPS_FLIP_EN
    chk("t4_flip_pulses", flips, 1);
    chk("t4_enable_cycles", en, 6);
    chk("t4_peak_out", mx, 4);
`else
    chk("t4_flip_pulses", flips, 0);
    chk("t4_enable_cycles", en, 9);
    chk("t4_peak_out", mx, 7);
`endif
    tick(); tick();

    // Abort mid-RUN with two programs queued and a simultaneous push
    push(4'd4, 4'd0, 4'd2);
    push(4'd3, 4'd0, 4'd1);
    push(4'd5, 4'd1, 4'd1);
    tick();
    chk("t5_running", cnt_enable, 1);
    tick();
    abort = 1'b1; cfg_valid = 1'b1; cfg_max = 4'd5; cfg_min = 4'd1; cfg_bounces = 4'd1;
    #1;
    chk("t5_abort_ready", cfg_ready, 0);
    tick();
    abort = 1'b0; cfg_valid = 1'b0;
    chk("t5_abort_outputs", {cnt_enable, busy, done, err}, 0);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || cnt_enable !== 1'b0) stray++;
    end
    chk("t5_fifo_flushed", stray, 0);

    // Reset during RUN with a second program queued
    push(4'd6, 4'd1, 4'd3);
    push(4'd3, 4'd0, 4'd1);
    tick(); tick();
    chk("t6_running", cnt_enable, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_cnt_rst_n", cnt_rst_n, 0);
    chk("t6_rst_outputs", {cnt_enable, cnt_flip, busy, done, err}, 0);
    chk("t6_rst_max_min", {cnt_max, cnt_min}, 0);
    tick();
    chk("t6_post_rst_n", cnt_rst_n, 1);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy !== 1'b0) stray++;
    end
    chk("t6_fifo_empty", stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
